// File: rtl/reg_dump_serializer.sv
// Debug readout for a bank of CPU registers: snapshots the bank on a start
// pulse, then streams it MSB-first, register 0 first, over a valid/ready serial link.
module reg_dump_serializer #(
    parameter int REGISTER_WIDTH = 4,
    parameter int NUM_REGS       = 4,
    localparam int IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    input  logic [NUM_REGS*REGISTER_WIDTH-1:0] regs_i,
    input  logic                               ready_i,
    output logic                               ser_o,
    output logic                               ser_valid_o,
    output logic                               frame_o,
    output logic [IDX_W-1:0]                   idx_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int BIT_W = (REGISTER_WIDTH > 1) ? $clog2(REGISTER_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(REGISTER_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [REGISTER_WIDTH-1:0] snap_q [NUM_REGS];
    logic [REGISTER_WIDTH-1:0] snap_d [NUM_REGS];
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    logic                      xfer;
    logic                      last_bit;
    logic                      last_reg;
    logic [REGISTER_WIDTH-1:0] cur_reg;
    logic [REGISTER_WIDTH-1:0] cur_shifted;

    always_comb begin
        xfer     = (state_q == SHIFT) && ready_i;
        last_bit = (bit_cnt_q == LAST_BIT);
        last_reg = (idx_q == LAST_IDX);
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        snap_d[k] = regs_i[k*REGISTER_WIDTH +: REGISTER_WIDTH];
                    end
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        // Counters are left at zero so idx_o reads 0 outside a dump.
                        if (last_reg) begin
                            idx_d   = '0;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
        end
    end

    // Shifting left by the bit count brings the bit being sent into the MSB slot.
    always_comb begin
        cur_reg     = snap_q[idx_q];
        cur_shifted = cur_reg << bit_cnt_q;
    end

    always_comb begin
        ser_valid_o = (state_q == SHIFT);
        busy_o      = (state_q == SHIFT);
        done_o      = (state_q == DONE);
        ser_o       = (state_q == SHIFT) && cur_shifted[REGISTER_WIDTH-1];
        frame_o     = (state_q == SHIFT) && (bit_cnt_q == '0);
        idx_o       = idx_q;
    end

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Scoreboard bench for reg_dump_serializer: expected bits are queued when a
// dump is started and popped as the DUT hands them over.
module tb_reg_dump_serializer;

   localparam int W    = 4;
   localparam int N    = 4;
   localparam int BITS = W * N;
   localparam logic [BITS-1:0] BASIC = {4'b0000, 4'b1111, 4'b1110, 4'b1010};

   logic            clk_i = 1'b0;
   logic            reset_i;
   logic            start_i;
   logic [BITS-1:0] regs_i;
   logic            ready_i;
   logic            ser_o;
   logic            ser_valid_o;
   logic            frame_o;
   logic [1:0]      idx_o;
   logic            busy_o;
   logic            done_o;

   typedef struct packed {
      logic       ser;
      logic       frame;
      logic [1:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   reg_dump_serializer #(.REGISTER_WIDTH(W), .NUM_REGS(N)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .regs_i      (regs_i),
      .ready_i     (ready_i),
      .ser_o       (ser_o),
      .ser_valid_o (ser_valid_o),
      .frame_o     (frame_o),
      .idx_o       (idx_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference stream for one dump: register 0 first, MSB first, frame on the MSB.
   task automatic push_dump(input logic [BITS-1:0] r);
      exp_t e;
      for (int k = 0; k < N; k++) begin
         for (int b = W - 1; b >= 0; b--) begin
            e.ser   = r[k*W + b];
            e.frame = (b == W - 1);
            e.idx   = 2'(k);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      start_i = 1'b1;
      ready_i = 1'b1;
      regs_i  = BASIC;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk_i);
         checks++;
         if ({ser_o, ser_valid_o, frame_o, idx_o, busy_o, done_o} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs cycle=%0d actual=%b required=0000000", n,
                     {ser_o, ser_valid_o, frame_o, idx_o, busy_o, done_o});
         end
      end
      reset_i = 1'b1;
      start_i = 1'b0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk_i);
         checks++;
         if ({busy_o, ser_valid_o, done_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_release_idle actual=%b required=000", {busy_o, ser_valid_o, done_o});
         end
      end
   endtask

   task automatic test_basic_dump();
      int   pos;
      int   done_at;
      exp_t e;
      regs_i  = BASIC;
      ready_i = 1'b1;
      start_i = 1'b1;
      push_dump(BASIC);
      pos     = 0;
      done_at = 0;
      for (int n = 1; n <= 40 && done_at == 0; n++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         if (ser_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL basic_extra_bit actual=valid required=no_bit");
            end else begin
               e = exp_q[0];
               if ({ser_o, frame_o, idx_o} !== {e.ser, e.frame, e.idx}) begin
                  failures++;
                  $display("[TB] FAIL basic_bit pos=%0d actual=%b required=%b", pos,
                           {ser_o, frame_o, idx_o}, {e.ser, e.frame, e.idx});
               end
               if (ready_i) begin
                  void'(exp_q.pop_front());
                  pos++;
               end
            end
         end
         if (done_o) done_at = n;
      end
      checks++;
      if (done_at != 17) begin
         failures++;
         $display("[TB] FAIL basic_done_cycle actual=%0d required=17", done_at);
      end
      checks++;
      if (pos != BITS || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL basic_bit_count actual=%0d required=%0d", pos, BITS);
      end
      exp_q.delete();
      @(negedge clk_i);
      checks++;
      if ({done_o, busy_o} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL basic_done_pulse actual=%b required=00", {done_o, busy_o});
      end
   endtask

   task automatic test_backpressure();
      int   pos;
      int   done_at;
      int   stalls;
      exp_t e;
      regs_i  = BASIC;
      ready_i = 1'b1;
      start_i = 1'b1;
      push_dump(BASIC);
      pos     = 0;
      done_at = 0;
      stalls  = 0;
      for (int n = 1; n <= 40 && done_at == 0; n++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         ready_i = !(pos == 6 && stalls < 3);
         if (!ready_i) begin
            stalls++;
            checks++;
            if ({ser_valid_o, ser_o, idx_o} !== 4'b1101) begin
               failures++;
               $display("[TB] FAIL bp_hold stall=%0d actual=%b required=1101", stalls,
                        {ser_valid_o, ser_o, idx_o});
            end
         end
         if (ser_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL bp_extra_bit actual=valid required=no_bit");
            end else begin
               e = exp_q[0];
               if ({ser_o, frame_o, idx_o} !== {e.ser, e.frame, e.idx}) begin
                  failures++;
                  $display("[TB] FAIL bp_bit pos=%0d actual=%b required=%b", pos,
                           {ser_o, frame_o, idx_o}, {e.ser, e.frame, e.idx});
               end
               if (ready_i) begin
                  void'(exp_q.pop_front());
                  pos++;
               end
            end
         end
         if (done_o) done_at = n;
      end
      ready_i = 1'b1;
      checks++;
      if (done_at != 20) begin
         failures++;
         $display("[TB] FAIL bp_done_cycle actual=%0d required=20", done_at);
      end
      checks++;
      if (pos != BITS || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL bp_bit_count actual=%0d required=%0d", pos, BITS);
      end
      exp_q.delete();
      @(negedge clk_i);
   endtask

   task automatic test_snapshot_isolation();
      int   pos;
      int   done_at;
      exp_t e;
      regs_i  = BASIC;
      ready_i = 1'b1;
      start_i = 1'b1;
      push_dump(BASIC);
      pos     = 0;
      done_at = 0;
      for (int n = 1; n <= 40 && done_at == 0; n++) begin
         @(negedge clk_i);
         start_i = (n == 3);
         if (n == 3) regs_i = {4'b0101, 4'b0101, 4'b0101, 4'b0101};
         if (ser_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL iso_extra_bit actual=valid required=no_bit");
            end else begin
               e = exp_q[0];
               if ({ser_o, frame_o, idx_o} !== {e.ser, e.frame, e.idx}) begin
                  failures++;
                  $display("[TB] FAIL iso_bit pos=%0d actual=%b required=%b", pos,
                           {ser_o, frame_o, idx_o}, {e.ser, e.frame, e.idx});
               end
               if (ready_i) begin
                  void'(exp_q.pop_front());
                  pos++;
               end
            end
         end
         if (done_o) done_at = n;
      end
      start_i = 1'b0;
      checks++;
      if (done_at != 17) begin
         failures++;
         $display("[TB] FAIL iso_done_cycle actual=%0d required=17", done_at);
      end
      exp_q.delete();
      for (int n = 0; n < 4; n++) begin
         @(negedge clk_i);
         checks++;
         if ({busy_o, ser_valid_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL iso_no_second_dump cycle=%0d actual=%b required=00", n, {busy_o, ser_valid_o});
         end
      end
      regs_i = BASIC;
   endtask

   task automatic test_reset_mid_dump();
      int   pos;
      int   done_at;
      exp_t e;
      regs_i  = BASIC;
      ready_i = 1'b1;
      start_i = 1'b1;
      push_dump(BASIC);
      pos = 0;
      for (int n = 1; n <= 40 && pos < 9; n++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         if (ser_valid_o && exp_q.size() != 0) begin
            e = exp_q[0];
            checks++;
            if ({ser_o, frame_o, idx_o} !== {e.ser, e.frame, e.idx}) begin
               failures++;
               $display("[TB] FAIL rst_pre_bit pos=%0d actual=%b required=%b", pos,
                        {ser_o, frame_o, idx_o}, {e.ser, e.frame, e.idx});
            end
            void'(exp_q.pop_front());
            pos++;
         end
      end
      #2 reset_i = 1'b0;
      #1;
      checks++;
      if ({ser_o, ser_valid_o, frame_o, idx_o, busy_o, done_o} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL rst_async_clear actual=%b required=0000000",
                  {ser_o, ser_valid_o, frame_o, idx_o, busy_o, done_o});
      end
      exp_q.delete();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk_i);
         checks++;
         if ({done_o, busy_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rst_no_done actual=%b required=00", {done_o, busy_o});
         end
      end
      reset_i = 1'b1;
      start_i = 1'b1;
      push_dump(BASIC);
      pos     = 0;
      done_at = 0;
      for (int n = 1; n <= 40 && done_at == 0; n++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         if (ser_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL rst_extra_bit actual=valid required=no_bit");
            end else begin
               e = exp_q[0];
               if ({ser_o, frame_o, idx_o} !== {e.ser, e.frame, e.idx}) begin
                  failures++;
                  $display("[TB] FAIL rst_redump_bit pos=%0d actual=%b required=%b", pos,
                           {ser_o, frame_o, idx_o}, {e.ser, e.frame, e.idx});
               end
               void'(exp_q.pop_front());
               pos++;
            end
         end
         if (done_o) done_at = n;
      end
      checks++;
      if (done_at != 17 || pos != BITS) begin
         failures++;
         $display("[TB] FAIL rst_redump_done actual=cycle%0d/bits%0d required=cycle17/bits%0d", done_at, pos, BITS);
      end
      exp_q.delete();
      @(negedge clk_i);
   endtask

   task automatic test_back_to_back();
      int              pos;
      int              done1;
      int              done2;
      exp_t            e;
      logic [BITS-1:0] r;
      r       = 16'h3C96;
      regs_i  = r;
      ready_i = 1'b1;
      start_i = 1'b1;
      push_dump(r);
      push_dump(r);
      pos   = 0;
      done1 = 0;
      done2 = 0;
      for (int n = 1; n <= 60 && done2 == 0; n++) begin
         @(negedge clk_i);
         if (ser_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL b2b_extra_bit actual=valid required=no_bit");
            end else begin
               e = exp_q[0];
               if ({ser_o, frame_o, idx_o} !== {e.ser, e.frame, e.idx}) begin
                  failures++;
                  $display("[TB] FAIL b2b_bit pos=%0d actual=%b required=%b", pos,
                           {ser_o, frame_o, idx_o}, {e.ser, e.frame, e.idx});
               end
               void'(exp_q.pop_front());
               pos++;
            end
         end
         if (n == 18) begin
            checks++;
            if ({busy_o, ser_valid_o, done_o} !== 3'b000) begin
               failures++;
               $display("[TB] FAIL b2b_idle_gap actual=%b required=000", {busy_o, ser_valid_o, done_o});
            end
         end
         if (done_o) begin
            if (done1 == 0) done1 = n;
            else begin
               done2   = n;
               start_i = 1'b0;
            end
         end
      end
      start_i = 1'b0;
      checks++;
      if (done1 != 17 || done2 != 35) begin
         failures++;
         $display("[TB] FAIL b2b_period actual=%0d,%0d required=17,35", done1, done2);
      end
      checks++;
      if (pos != 2 * BITS) begin
         failures++;
         $display("[TB] FAIL b2b_bit_count actual=%0d required=%0d", pos, 2 * BITS);
      end
      exp_q.delete();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk_i);
         checks++;
         if (busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_stop actual=%b required=0", busy_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_dump();
      test_backpressure();
      test_snapshot_isolation();
      test_reset_mid_dump();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
